// File: rtl/sha_digest_uart_tx.sv
// SHA-1 digest return path: latches a 160-bit digest and sends it MSB byte first over an 8N1 UART.
// Define DIGEST_HEX_ASCII_EN to send uppercase ASCII hex plus CR/LF instead of 20 raw bytes.
module sha_digest_uart_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [159:0] din,
   input  logic         din_vld,
   output logic         busy,
   output logic         done,
   output logic         overrun,
   output logic         uart_tx
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef DIGEST_HEX_ASCII_EN
   localparam logic [5:0] LAST  = 6'd41;
   localparam int         SHIFT = 4;
`else
   localparam logic [5:0] LAST  = 6'd19;
   localparam int         SHIFT = 8;
`endif

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [159:0]     sr;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [5:0]       byte_idx;
   logic [7:0]       cur_char;
   logic             baud_end;

`ifdef DIGEST_HEX_ASCII_EN
   function automatic logic [7:0] hex_char(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      else           return 8'h37 + {4'h0, n};
   endfunction
`endif

   // The character on the wire always comes from the top of the shift register.
   always_comb begin
`ifdef DIGEST_HEX_ASCII_EN
      if (byte_idx == 6'd40)      cur_char = 8'h0D;
      else if (byte_idx == 6'd41) cur_char = 8'h0A;
      else                        cur_char = hex_char(sr[159:156]);
`else
      cur_char = sr[159:152];
`endif
   end

   assign baud_end = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         sr       <= '0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overrun  <= 1'b0;
         uart_tx  <= 1'b1;
      end else begin
         done    <= 1'b0;
         overrun <= din_vld && busy;
         case (state)
            IDLE: begin
               if (din_vld) begin
                  sr       <= din;
                  byte_idx <= '0;
                  bit_idx  <= '0;
                  baud_cnt <= '0;
                  state    <= START;
                  busy     <= 1'b1;
                  uart_tx  <= 1'b0;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  uart_tx  <= cur_char[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state   <= STOP;
                     uart_tx <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     uart_tx <= cur_char[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (byte_idx < LAST) begin
                     // Next start bit follows the stop bit with no idle gap.
                     byte_idx <= byte_idx + 6'd1;
                     sr       <= sr << SHIFT;
                     state    <= START;
                     uart_tx  <= 1'b0;
                  end else begin
                     state   <= IDLE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     uart_tx <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha_digest_uart_tx.sv
// Self-checking bench for sha_digest_uart_tx with CLKS_PER_BIT=4; honours DIGEST_HEX_ASCII_EN.
module tb_sha_digest_uart_tx;

   localparam int C    = 4;
   localparam int BITC = 10 * C;
`ifdef DIGEST_HEX_ASCII_EN
   localparam int NCH = 42;
`else
   localparam int NCH = 20;
`endif

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [159:0] din = '0;
   logic         din_vld = 1'b0;
   logic         busy, done, overrun, uart_tx;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   logic [7:0] exp_ch [NCH];

   sha_digest_uart_tx #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .rstn(rstn), .din(din), .din_vld(din_vld),
      .busy(busy), .done(done), .overrun(overrun), .uart_tx(uart_tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected character stream for a digest, built directly from the byte/nibble ordering rules.
   function automatic void model(input logic [159:0] d);
      string hx = "0123456789ABCDEF";
      for (int k = 0; k < 20; k++) begin
         logic [7:0] b;
         b = d[159 - 8*k -: 8];
`ifdef DIGEST_HEX_ASCII_EN
         exp_ch[2*k]     = hx[b[7:4]];
         exp_ch[2*k + 1] = hx[b[3:0]];
`else
         exp_ch[k] = b;
`endif
      end
`ifdef DIGEST_HEX_ASCII_EN
      exp_ch[40] = 8'h0D;
      exp_ch[41] = 8'h0A;
`endif
   endfunction

   function automatic logic [159:0] rand160();
      return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic start(input logic [159:0] d);
      din     = d;
      din_vld = 1'b1;
      @(negedge clk);
      din_vld = 1'b0;
   endtask

   // Entered at the negedge of cycle N+1; watches one whole frame cycle by cycle.
   task automatic frame(input logic [159:0] d, input int ov_at, input int rst_at,
                        input bit chain, input logic [159:0] nd);
      logic [9:0] fr;
      bit busy_ok = 1'b1;
      bit ov_ok   = 1'b1;
      fr = '0;
      model(d);
      chk("first_busy", busy, 1);
      chk("first_tx", uart_tx, 0);
      for (int t = 0; t < NCH*BITC; t++) begin
         if (t == rst_at) begin
            rstn = 1'b0;
            #1;
            chk("rst_tx_async", uart_tx, 1);
            chk("rst_busy_async", busy, 0);
            @(negedge clk);
            chk("rst_hold_tx", uart_tx, 1);
            chk("rst_hold_done", done, 0);
            chk("rst_hold_overrun", overrun, 0);
            rstn = 1'b1;
            return;
         end
         if (t % C == C/2) fr[(t % BITC) / C] = uart_tx;
         if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
         if (ov_at >= 0 && t == ov_at + 1) begin
            chk("overrun_pulse", overrun, 1);
            din_vld = 1'b0;
         end else if (overrun !== 1'b0) ov_ok = 1'b0;
         if (ov_at >= 0 && t == ov_at) begin
            din     = ~d;
            din_vld = 1'b1;
         end
         if (t % BITC == BITC - 1)
            chk($sformatf("char%0d", t / BITC), {22'b0, fr}, {22'b0, 1'b1, exp_ch[t / BITC], 1'b0});
         @(negedge clk);
      end
      chk("busy_during_frame", {31'b0, busy_ok}, 1);
      chk("no_stray_overrun", {31'b0, ov_ok}, 1);
      chk("done_pulse", done, 1);
      chk("busy_fall", busy, 0);
      chk("tx_idle_end", uart_tx, 1);
      if (chain) begin
         din     = nd;
         din_vld = 1'b1;
         @(negedge clk);
         din_vld = 1'b0;
      end else begin
         @(negedge clk);
         chk("done_one_cycle", done, 0);
         chk("busy_stays_low", busy, 0);
      end
   endtask

   initial begin
      logic [159:0] abc, d1, d2, d3, d4, d5;
      bit idle_ok;
      abc = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;

      repeat (3) @(negedge clk);
      chk("reset_tx", uart_tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_overrun", overrun, 0);
      rstn = 1'b1;

      idle_ok = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) idle_ok = 1'b0;
      end
      chk("idle_100", {31'b0, idle_ok}, 1);

      start(abc);
      frame(abc, -1, -1, 1'b0, '0);

      d1 = rand160();
      start(d1);
      frame(d1, 50, -1, 1'b0, '0);

      d2 = rand160();
      d3 = rand160();
      start(d2);
      frame(d2, -1, -1, 1'b1, d3);
      frame(d3, -1, -1, 1'b0, '0);

      d4 = rand160();
      start(d4);
      frame(d4, -1, 7*BITC + 3*C + 1, 1'b0, '0);
      idle_ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
      end
      chk("idle_after_reset", {31'b0, idle_ok}, 1);

      d5 = rand160();
      start(d5);
      frame(d5, -1, -1, 1'b0, '0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
